// File: rtl/dac_serial_tx_pkg.sv
// Shared defaults and state encoding for the DDS-to-DAC serial transmitter.
package dac_serial_tx_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDiv   = 2;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/dac_serial_tx_sclk_gen.sv
// Serial bit-clock divider: sclk toggles every DIV enabled cycles, idles low when cleared.
module dac_serial_tx_sclk_gen
  import dac_serial_tx_pkg::*;
#(
  parameter int unsigned DIV = DefDiv
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(DIV - 1);

  logic [CntW-1:0] div_q, div_d;
  logic            sclk_q, sclk_d;
  logic            tc;

  always_comb begin
    tc     = en_i && !clr_i && (div_q == TermCnt);
    div_d  = div_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      if (tc) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = tc && !sclk_q;
  assign fall_o = tc && sclk_q;

endmodule

// File: rtl/dac_serial_tx.sv
// Captures DDS samples into a one-deep hold buffer and shifts them MSB-first to a serial DAC.
module dac_serial_tx
  import dac_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DIV   = DefDiv
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample,
  input  logic             new_sample_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             sync_n,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             hold_valid_q, hold_valid_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             sync_n_q, sync_n_d;
  logic             sdata_q, sdata_d;
  logic             overrun_q, overrun_d;
  logic             load;
  logic             sclk_fall;
  logic             unused_sclk_rise;

  dac_serial_tx_sclk_gen #(
    .DIV(DIV)
  ) u_sclk_gen (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (state_q == StShift),
    .clr_i  (state_q == StIdle),
    .sclk_o (sclk),
    .rise_o (unused_sclk_rise),
    .fall_o (sclk_fall)
  );

  assign load = (state_q == StIdle) && hold_valid_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    sync_n_d     = sync_n_q;
    sdata_d      = sdata_q;
    overrun_d    = overrun_q;

    if (load) hold_valid_d = 1'b0;
    // A strobe on the transfer edge refills hold without losing anything.
    if (new_sample_ready) begin
      hold_d       = sample;
      hold_valid_d = 1'b1;
      if (hold_valid_q && !load) overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) begin
          shift_d   = hold_q;
          sdata_d   = hold_q[WIDTH-1];
          bit_cnt_d = CntW'(WIDTH - 1);
          sync_n_d  = 1'b0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (sclk_fall) begin
          if (bit_cnt_q != '0) begin
            shift_d   = shift_q << 1;
            sdata_d   = shift_q[WIDTH-2];
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            sync_n_d = 1'b1;
            sdata_d  = 1'b0;
            state_d  = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sync_n_q     <= 1'b1;
      sdata_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sync_n_q     <= sync_n_d;
      sdata_q      <= sdata_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sdata   = sdata_q;
  assign sync_n  = sync_n_q;
  assign busy    = (state_q == StShift) || hold_valid_q;
  assign overrun = overrun_q;

endmodule
